// File: rtl/gate_arbiter.sv
// Shared registered bitwise logic unit with N-requester valid/ready arbitration.
// Build option: define GATE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module gate_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [3*N-1:0]   req_op,
  input  logic [W*N-1:0]   req_a,
  input  logic [W*N-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [IDW-1:0]   rsp_id,
  output logic             rsp_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q, id_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   data_q, data_d;
  logic           err_q, err_d;

  logic [IDW-1:0] win_id;
  logic           win_found;
  logic [IDW:0]   cand;
  logic [W-1:0]   res;
  logic           res_err;

  logic [2:0]     op_arr [N];
  logic [W-1:0]   a_arr  [N];
  logic [W-1:0]   b_arr  [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign op_arr[g] = req_op[3*g +: 3];
    assign a_arr[g]  = req_a[W*g +: W];
    assign b_arr[g]  = req_b[W*g +: W];
  end

`ifdef GATE_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [IDW-1:0] ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StResp && rsp_ready) begin
      ptr_d = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
    end
  end
`endif

  // Search from ptr upward with wrap; cand stays below 2N so IDW+1 bits suffice.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  assign req_ready = (rst_n && state_q == StIdle && win_found) ? (N'(1) << win_id) : '0;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op_q)
      3'd0:    res = a_q & b_q;
      3'd1:    res = a_q | b_q;
      3'd2:    res = ~(a_q & b_q);
      3'd3:    res = a_q ^ b_q;
      3'd4:    res = ~(a_q | b_q);
      3'd5:    res = ~(a_q ^ b_q);
      3'd6:    res = ~a_q;
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          id_d    = win_id;
          op_d    = op_arr[win_id];
          a_d     = a_arr[win_id];
          b_d     = b_arr[win_id];
          state_d = StExec;
        end
      end
      StExec: begin
        data_d  = res;
        err_d   = res_err;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      id_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule
